// File: rtl/prng_range_fetch.sv
// Prefetches raw xoshiro128++ words into a small FIFO and turns them into unbiased
// integers in [0, bound) by masking to the next power of two and rejecting out-of-range candidates.
module prng_range_fetch #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       prng_next,
  input  logic                       prng_hold,
  input  logic [31:0]                prng_rnd,
  input  logic                       flush,
  input  logic [31:0]                bound,
  input  logic                       rd_req,
  output logic [31:0]                rd_data,
  output logic                       rd_valid,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           reject_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW:0] DEPTH_W = (LW+1)'(DEPTH);

  typedef enum logic {IDLE, SEARCH} state_t;

  state_t            state_q, state_d;
  logic              fill_en_q;
  logic              inflight_q;
  logic [LW-1:0]     level_q, level_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]       bound_q, bound_d, mask_q, mask_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0]  reject_cnt_q, reject_cnt_d;
  logic [31:0]       mem_q [DEPTH];

  logic        push, pop, accept;
  logic [31:0] head, cand;

  // Set every bit at and below the most significant set bit.
  function automatic logic [31:0] smear(input logic [31:0] x);
    logic [31:0] s;
    s = x;
    s = s | (s >> 1);
    s = s | (s >> 2);
    s = s | (s >> 4);
    s = s | (s >> 8);
    s = s | (s >> 16);
    return s;
  endfunction

  // Counting the in-flight word keeps the FIFO from ever overflowing on arrival.
  assign prng_next = fill_en_q & ~flush & ~prng_hold &
                     (({1'b0, level_q} + (LW+1)'(inflight_q)) < DEPTH_W);

  always_comb begin
    push   = inflight_q & ~flush;
    head   = mem_q[rd_ptr_q];
    cand   = head & mask_q;
    pop    = (state_q == SEARCH) & ~flush & (level_q != '0);
    accept = pop & ((bound_q == 32'd0) | (cand < bound_q));

    state_d      = state_q;
    bound_d      = bound_q;
    mask_d       = mask_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
    reject_cnt_d = reject_cnt_q;
    wr_ptr_d     = wr_ptr_q + AW'(push);
    rd_ptr_d     = rd_ptr_q + AW'(pop);
    level_d      = level_q + LW'(push) - LW'(pop);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end

    case (state_q)
      IDLE: begin
        if (rd_req && !flush) begin
          state_d = SEARCH;
          bound_d = bound;
          mask_d  = smear(bound - 32'd1);
        end
      end
      SEARCH: begin
        if (flush) begin
          state_d = IDLE;
        end else if (accept) begin
          state_d    = IDLE;
          rd_data_d  = cand;
          rd_valid_d = 1'b1;
        end else if (pop && reject_cnt_q != '1) begin
          reject_cnt_d = reject_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fill_en_q    <= 1'b0;
      inflight_q   <= 1'b0;
      level_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      bound_q      <= '0;
      mask_q       <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      reject_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      fill_en_q    <= 1'b1;
      inflight_q   <= prng_next;
      level_q      <= level_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      bound_q      <= bound_d;
      mask_q       <= mask_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      reject_cnt_q <= reject_cnt_d;
    end
  end

  // Storage is data-only; occupancy is tracked by level_q, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= prng_rnd;
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign busy       = (state_q == SEARCH);
  assign level      = level_q;
  assign reject_cnt = reject_cnt_q;
endmodule

// File: doc/prng_range_fetch.md
Name: prng_range_fetch

Overview:
- Sits directly downstream of the xoshiro128++ generator in the PRNG peripheral.
- Drives the generator's `next` strobe to keep a small prefetch FIFO of raw 32-bit words full.
- On request, turns FIFO words into an unbiased integer in [0, bound) using power-of-two masking with rejection.
- Output is a registered word plus a one-cycle valid pulse, read by the peripheral register interface.

Parameters:
- DEPTH, 4, number of raw-word FIFO entries. Power of two, ≥2.
- CNT_W, 16, width of the saturating rejection counter.

Ports:
- clk  input  1  system clock, single clock domain.
- rst_n  input  1  reset, asynchronous assert, active-low.
- prng_next  output  1  advance strobe to generator; generator's registered rnd is valid the following cycle.
- prng_hold  input  1  generator is taking a seed write this cycle; any next this cycle would be ignored by it.
- prng_rnd  input  32  generator output word.
- flush  input  1  discard FIFO contents, in-flight word and any pending request (asserted on reseed).
- bound  input  32  range for the request; sampled with rd_req. 0 = full 32-bit raw word.
- rd_req  input  1  request one ranged value; ignored unless idle.
- rd_data  output  32  ranged result, held until next result.
- rd_valid  output  1  one-cycle pulse: rd_data updated.
- busy  output  1  request accepted and not yet completed.
- level  output  clog2(DEPTH)+1  FIFO occupancy.
- reject_cnt  output  CNT_W  rejected candidates since reset, saturating at all-ones.

Behaviour:
- Reset (async, rst_n low):
  - FIFO empty, inflight=0, fill_en=0, state IDLE.
  - rd_data=0, rd_valid=0, busy=0, reject_cnt=0, level=0, bound_q=0, mask_q=0.
  - prng_next=0 while rst_n low and in the first cycle after release (fill_en goes to 1 at the first edge after release).
- Fill:
  - prng_next = fill_en & !flush & !prng_hold & (level + inflight < DEPTH), combinational.
  - inflight <= prng_next (registered).
  - When inflight=1 and flush=0, prng_rnd is pushed at that edge; space is guaranteed by the issue rule.
  - Back-to-back issue every cycle is allowed; inflight never exceeds 1.
- Mask:
  - On rd_req accept, latch bound_q=bound and mask_q = smear(bound-1), i.e. all bits at and below the MSB of bound-1 set.
  - bound=1 gives mask 0 (result always 0). bound=0 gives mask all-ones and no rejection.
- FSM:
  - IDLE: rd_req=1 & !flush → SEARCH, busy=1.
  - SEARCH, each edge:
    - flush → IDLE, no rd_valid.
    - FIFO empty → stay.
    - else pop head, cand = head & mask_q.
      - If bound_q==0 or cand < bound_q: rd_data<=cand, rd_valid<=1, → IDLE.
      - Else reject: reject_cnt += 1 (saturating), stay in SEARCH.
- Latency:
  - rd_req in cycle 0 with FIFO non-empty and first candidate accepted → rd_valid high in cycle 2.
  - Each rejection adds 1 cycle. An empty FIFO adds the fill latency (2 cycles from next to the word being available).
- Simultaneous events:
  - Push and pop on the same edge: level unchanged, FIFO order preserved.
  - A pop may consume a word pushed on an earlier edge only, never the word arriving on the same edge.
- flush:
  - Clears the FIFO; the word arriving for a pending inflight is dropped.
  - rd_req is ignored the same cycle. rd_data and reject_cnt are unchanged.
- rd_valid is never asserted in two consecutive cycles. A new rd_req in the cycle rd_valid is high is accepted.
- Pointers wrap modulo DEPTH. The level counter distinguishes full from empty.

Test Plan:
- Bench stub returns 0x11111111, 0x22222222, ... on successive next strobes. After reset, expect:
  - prng_next high from the second cycle after release.
  - level reaches 4.
  - prng_next falls when level+inflight=4.
- bound=0, rd_req with full FIFO → rd_valid in cycle 2, rd_data=0x11111111. Then level returns to 4 and 0x55555555 is fetched.
- bound=10 (mask 0xF):
  - Stub words 0x0000000C, 0x0000001F, 0x00000007 → two rejects, rd_data=7.
  - reject_cnt=2, rd_valid exactly 4 cycles after rd_req.
- bound=1 → rd_data=0 for any word. bound=0x80000001 → mask 0xFFFFFFFF; word 0x80000001 is rejected, 0x80000000 is accepted.
- prng_hold held high for 3 cycles during fill → no prng_next in those cycles, no spurious push, FIFO order intact.
- flush asserted while SEARCH is waiting on an empty FIFO with inflight=1 → no rd_valid, busy=0, and the in-flight word is not pushed (level=0 next cycle).
